// File: rtl/memoria_dados_param.sv
// Parameterised word-addressed data memory with byte-masked writes.
// After reset the array is zeroed one word per cycle (LIMPANDO state);
// once every word is cleared the block serves single-cycle requests (OPERANDO).
// Out-of-range accesses never touch the array and are flagged on erro.
module memoria_dados_param #(
   parameter int LARGURA      = 32,
   parameter int PROFUNDIDADE = 50,
   parameter int LARGURA_END  = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req,
   input  logic                     controle_escrita,
   input  logic [LARGURA_END-1:0]   endereco,
   input  logic [LARGURA-1:0]       data,
   input  logic [LARGURA/8-1:0]     mascara_bytes,
   output logic                     pronto,
   output logic [LARGURA-1:0]       saida,
   output logic                     saida_valida,
   output logic                     erro
);

   localparam int NBYTES = LARGURA / 8;
   localparam int CONT_W = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
   localparam logic [CONT_W-1:0]      CONT_ULTIMO = CONT_W'(PROFUNDIDADE - 1);
   // Full-width limit: the range check never looks at a truncated address.
   localparam logic [LARGURA_END-1:0] END_LIMITE  = LARGURA_END'(PROFUNDIDADE);

   typedef enum logic [0:0] {
      LIMPANDO = 1'b0,
      OPERANDO = 1'b1
   } estado_t;

   // Replace only the bytes selected by the mask; unselected bytes keep the old value.
   function automatic logic [LARGURA-1:0] mescla_bytes(
      input logic [LARGURA-1:0] antigo,
      input logic [LARGURA-1:0] novo,
      input logic [NBYTES-1:0]  mascara
   );
      logic [LARGURA-1:0] resultado;
      resultado = antigo;
      for (int i = 0; i < NBYTES; i++) begin
         if (mascara[i]) begin
            resultado[8*i +: 8] = novo[8*i +: 8];
         end else begin
            resultado[8*i +: 8] = antigo[8*i +: 8];
         end
      end
      return resultado;
   endfunction

   logic [LARGURA-1:0] mem [0:PROFUNDIDADE-1];

   estado_t             estado_q;
   logic [CONT_W-1:0]   contador_q;
   logic [LARGURA-1:0]  saida_q;
   logic                saida_valida_q;
   logic                erro_q;

   logic                pronto_s;
   logic                aceita_s;
   logic                em_faixa_s;
   logic [CONT_W-1:0]   idx_s;
   logic [LARGURA-1:0]  palavra_lida_s;
   logic                mem_we_d;
   logic [CONT_W-1:0]   mem_idx_d;
   logic [LARGURA-1:0]  mem_wdata_d;

   assign pronto_s       = (estado_q == OPERANDO);
   assign aceita_s       = req & pronto_s;
   assign em_faixa_s     = (endereco < END_LIMITE);
   // Only meaningful when em_faixa_s is set; the range check gates every use.
   assign idx_s          = endereco[CONT_W-1:0];
   assign palavra_lida_s = mem[idx_s];

   // Select the array write port source: clearing counter during init, masked request write otherwise.
   always_comb begin
      mem_we_d    = 1'b0;
      mem_idx_d   = contador_q;
      mem_wdata_d = '0;
      case (estado_q)
         LIMPANDO: begin
            mem_we_d    = 1'b1;
            mem_idx_d   = contador_q;
            mem_wdata_d = '0;
         end
         OPERANDO: begin
            mem_we_d    = aceita_s & controle_escrita & em_faixa_s;
            mem_idx_d   = idx_s;
            mem_wdata_d = mescla_bytes(palavra_lida_s, data, mascara_bytes);
         end
         default: begin
            mem_we_d    = 1'b0;
            mem_idx_d   = contador_q;
            mem_wdata_d = '0;
         end
      endcase
   end

   // Storage array: contents are defined by the init sweep, so it carries no reset.
   always_ff @(posedge clock) begin
      if (mem_we_d) begin
         mem[mem_idx_d] <= mem_wdata_d;
      end
   end

   // Init/operate FSM with registered read data and one-cycle response pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q       <= LIMPANDO;
         contador_q     <= '0;
         saida_q        <= '0;
         saida_valida_q <= 1'b0;
         erro_q         <= 1'b0;
      end else begin
         case (estado_q)
            LIMPANDO: begin
               saida_valida_q <= 1'b0;
               erro_q         <= 1'b0;
               if (contador_q == CONT_ULTIMO) begin
                  estado_q   <= OPERANDO;
                  contador_q <= '0;
               end else begin
                  contador_q <= contador_q + CONT_W'(1);
               end
            end
            OPERANDO: begin
               saida_valida_q <= 1'b0;
               erro_q         <= 1'b0;
               if (aceita_s) begin
                  erro_q <= ~em_faixa_s;
                  if (!controle_escrita) begin
                     saida_valida_q <= 1'b1;
                     saida_q        <= em_faixa_s ? palavra_lida_s : '0;
                  end
               end
            end
            default: begin
               estado_q       <= LIMPANDO;
               contador_q     <= '0;
               saida_valida_q <= 1'b0;
               erro_q         <= 1'b0;
            end
         endcase
      end
   end

   assign pronto       = pronto_s;
   assign saida        = saida_q;
   assign saida_valida = saida_valida_q;
   assign erro         = erro_q;

endmodule

// File: tb/tb_memoria_dados_param.sv
// Self-checking bench for memoria_dados_param: directed scenarios plus
// random traffic compared against an array-based reference model.
module tb_memoria_dados_param;

   localparam int W  = 32;
   localparam int D  = 50;
   localparam int AW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          req;
   logic          controle_escrita;
   logic [AW-1:0] endereco;
   logic [W-1:0]  data;
   logic [3:0]    mascara_bytes;
   logic          pronto;
   logic [W-1:0]  saida;
   logic          saida_valida;
   logic          erro;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   logic [W-1:0] ref_mem [D];
   logic [W-1:0] ref_saida;

   memoria_dados_param #(.LARGURA(W), .PROFUNDIDADE(D), .LARGURA_END(AW)) dut (
      .clock            (clock),
      .reset            (reset),
      .req              (req),
      .controle_escrita (controle_escrita),
      .endereco         (endereco),
      .data             (data),
      .mascara_bytes    (mascara_bytes),
      .pronto           (pronto),
      .saida            (saida),
      .saida_valida     (saida_valida),
      .erro             (erro)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Assert reset now, verify the asynchronous clear, release on a falling edge.
   task automatic hold_reset(input int ciclos);
      reset = 1'b1;
      req   = 1'b0;
      #1;
      check("rst_pronto", pronto, 0);
      check("rst_saida", saida, 0);
      check("rst_valida", saida_valida, 0);
      check("rst_erro", erro, 0);
      foreach (ref_mem[i]) ref_mem[i] = '0;
      ref_saida = '0;
      repeat (ciclos) @(negedge clock);
      reset = 1'b0;
   endtask

   // Count rising edges until pronto appears; whatever request is driven is dropped afterwards.
   task automatic wait_init(input int esperado, input string tag);
      int k;
      for (k = 1; k <= 200; k++) begin
         @(posedge clock);
         #1;
         if (pronto) break;
      end
      req = 1'b0;
      check(tag, k, esperado);
   endtask

   task automatic access(input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic [3:0] m, input string tag);
      bit in_range;
      int ai;
      logic [W-1:0] faixa;
      in_range = (a < 32'(D));
      ai = in_range ? int'(a) : 0;
      @(negedge clock);
      req = 1'b1;
      controle_escrita = wr;
      endereco = a;
      data = d;
      mascara_bytes = m;
      @(posedge clock);
      #1;
      if (wr) begin
         if (in_range) begin
            for (int b = 0; b < 4; b++) begin
               if (m[b]) begin
                  faixa = 32'hFF << (8 * b);
                  ref_mem[ai] = (ref_mem[ai] & ~faixa) | (d & faixa);
               end
            end
         end
      end else begin
         ref_saida = in_range ? ref_mem[ai] : 32'h0;
      end
      check({tag, "_valida"}, saida_valida, wr ? 32'h0 : 32'h1);
      check({tag, "_erro"}, erro, in_range ? 32'h0 : 32'h1);
      check({tag, "_saida"}, saida, ref_saida);
   endtask

   task automatic idle(input string tag);
      @(negedge clock);
      req = 1'b0;
      @(posedge clock);
      #1;
      check({tag, "_valida"}, saida_valida, 0);
      check({tag, "_erro"}, erro, 0);
      check({tag, "_saida"}, saida, ref_saida);
   endtask

   initial begin
      bit wr;
      int r;
      reset = 1'b1;
      req = 1'b0;
      controle_escrita = 1'b0;
      endereco = '0;
      data = '0;
      mascara_bytes = '0;
      ref_saida = '0;
      foreach (ref_mem[i]) ref_mem[i] = '0;

      // Power-up, with a write attempted throughout init that must be ignored.
      @(negedge clock);
      hold_reset(3);
      req = 1'b1;
      controle_escrita = 1'b1;
      endereco = '0;
      data = 32'h1;
      mascara_bytes = 4'hF;
      wait_init(D, "init_cycles");
      access(1'b0, 32'd0, 32'h0, 4'h0, "ign_rd0");
      check("ign_word0", saida, 32'h0);
      for (int a = 1; a < D; a++) access(1'b0, 32'(a), 32'h0, 4'h0, "init_rd");
      idle("init_idle");

      // Byte masking.
      access(1'b1, 32'd7, 32'hAABBCCDD, 4'b1111, "mask_w1");
      access(1'b1, 32'd7, 32'h11223344, 4'b0101, "mask_w2");
      access(1'b1, 32'd7, 32'h99999999, 4'b0000, "mask_w0");
      access(1'b0, 32'd7, 32'h0, 4'h0, "mask_rd");
      check("mask_word", saida, 32'hAA22CC44);
      idle("mask_idle");

      // Out of range, including an address whose low bits alias word 3.
      access(1'b1, 32'd49, 32'h0BADF00D, 4'hF, "oor_w49");
      access(1'b1, 32'd50, 32'hDEADBEEF, 4'hF, "oor_w50");
      access(1'b0, 32'd50, 32'h0, 4'h0, "oor_r50");
      check("oor_saida", saida, 32'h0);
      access(1'b0, 32'd49, 32'h0, 4'h0, "oor_r49");
      check("oor_word49", saida, 32'h0BADF00D);
      access(1'b1, 32'd67, 32'h77777777, 4'hF, "oor_w67");
      access(1'b1, 32'h8000_0003, 32'h66666666, 4'hF, "oor_wbig");
      access(1'b0, 32'd3, 32'h0, 4'h0, "oor_r3");
      check("oor_word3", saida, 32'h0);

      // Back-to-back write then read on consecutive edges.
      access(1'b1, 32'd3, 32'h5, 4'hF, "b2b_w");
      access(1'b0, 32'd3, 32'h0, 4'h0, "b2b_r");
      check("b2b_word", saida, 32'h5);

      // Random traffic against the reference model.
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            idle("rnd_idle");
         end else begin
            wr = (r < 5);
            access(wr, 32'($urandom_range(0, 57)), $urandom, 4'($urandom_range(0, 15)), "rnd");
         end
      end
      idle("rnd_end");

      // Reset 20 cycles into init.
      @(negedge clock);
      hold_reset(2);
      repeat (20) @(posedge clock);
      #1;
      check("mid_pronto", pronto, 0);
      hold_reset(2);
      wait_init(D, "reinit_cycles");

      // Reset in operation right as a read pulse is showing.
      access(1'b1, 32'd3, 32'h9, 4'hF, "op_w3");
      access(1'b0, 32'd3, 32'h0, 4'h0, "op_r3");
      check("op_word3", saida, 32'h9);
      hold_reset(2);
      wait_init(D, "opreset_cycles");
      access(1'b0, 32'd3, 32'h0, 4'h0, "clr_r3");
      check("clr_word3", saida, 32'h0);
      idle("end_idle");

      if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
